// File: rtl/spare_signal_checker_if.sv
// Generator-to-checker bus: selection vectors in, decoded indices and sweep status out.
interface spare_signal_checker_if #(parameter int CNT_W = 9);
  logic [1:0]       spare_struct_type;
  logic [7:0]       DSSS;
  logic [3:0]       RLSS;
  logic [2:0]       idx_i, idx_j, idx_k, idx_p;
  logic [1:0]       idx_ri, idx_rj;
  logic             dec_valid;
  logic [CNT_W-1:0] combo_cnt;
  logic             done, complete, pop_err, order_err;

  modport master (
    output spare_struct_type, DSSS, RLSS,
    input  idx_i, idx_j, idx_k, idx_p, idx_ri, idx_rj,
    input  dec_valid, combo_cnt, done, complete, pop_err, order_err
  );

  modport slave (
    input  spare_struct_type, DSSS, RLSS,
    output idx_i, idx_j, idx_k, idx_p, idx_ri, idx_rj,
    output dec_valid, combo_cnt, done, complete, pop_err, order_err
  );
endinterface

// File: rtl/spare_signal_checker.sv
// Receive-side checker for the DSSS/RLSS spare-selection stream: decodes set-bit
// positions, checks popcount legality and descending order, counts the sweep.
module spare_signal_checker #(
  parameter int EXP_S12 = 70,
  parameter int EXP_S3  = 420,
  parameter int CNT_W   = 9
) (
  input logic clk,
  input logic rst,
  spare_signal_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [1:0]       prev_type;
  logic [11:0]      prev_key;
  logic [2:0]       i_q, j_q, k_q, p_q;
  logic [1:0]       ri_q, rj_q;
  logic             vld_q, done_q, complete_q, pop_q, order_q;
  logic [CNT_W-1:0] cnt_q;

  logic        s3, pat, type_chg, legal;
  logic [11:0] key;
  logic [2:0]  d_i, d_j, d_k, d_p;
  logic [1:0]  r_hi, r_lo;
  logic [CNT_W-1:0] exp_cnt;

  assign s3       = (bus.spare_struct_type == 2'b11);
  assign pat      = (bus.DSSS != 8'h00) && (bus.spare_struct_type != 2'b00);
  assign type_chg = (bus.spare_struct_type != prev_type);
  assign key      = {bus.DSSS, bus.RLSS};
  assign exp_cnt  = s3 ? CNT_W'(EXP_S3) : CNT_W'(EXP_S12);
  assign legal    = ($countones(bus.DSSS) == 4) &&
                    (s3 ? ($countones(bus.RLSS) == 2) : (bus.RLSS == 4'h0));

  // Ascending scan shifts each new set bit in at the top, so the four highest
  // survive and absent positions stay 0.
  always_comb begin
    d_i = '0; d_j = '0; d_k = '0; d_p = '0;
    r_hi = '0; r_lo = '0;
    for (int b = 0; b < 8; b++)
      if (bus.DSSS[b]) begin
        d_p = d_k; d_k = d_j; d_j = d_i; d_i = 3'(b);
      end
    if (s3)
      for (int b = 0; b < 4; b++)
        if (bus.RLSS[b]) begin
          r_lo = r_hi; r_hi = 2'(b);
        end
  end

  always_ff @(posedge clk) begin
    // Sampled even in reset so a stable type across reset is not a change.
    prev_type <= bus.spare_struct_type;
    if (!rst) begin
      state <= IDLE;
      prev_key <= '0;
      i_q <= '0; j_q <= '0; k_q <= '0; p_q <= '0; ri_q <= '0; rj_q <= '0;
      vld_q <= 1'b0; cnt_q <= '0;
      done_q <= 1'b0; complete_q <= 1'b0; pop_q <= 1'b0; order_q <= 1'b0;
    end else if (type_chg) begin
      state <= IDLE;
      prev_key <= '0;
      vld_q <= 1'b0; cnt_q <= '0;
      done_q <= 1'b0; complete_q <= 1'b0; pop_q <= 1'b0; order_q <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (pat) begin
        vld_q <= 1'b1;
        i_q <= d_i; j_q <= d_j; k_q <= d_k; p_q <= d_p;
        ri_q <= r_hi; rj_q <= r_lo;
        if (!legal) pop_q <= 1'b1;
        case (state)
          IDLE: begin
            state <= RUN;
            cnt_q <= CNT_W'(1);
            prev_key <= key;
          end
          RUN: begin
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            if (key >= prev_key) order_q <= 1'b1;
            prev_key <= key;
          end
          default: order_q <= 1'b1;
        endcase
      end else if (state == RUN) begin
        state <= DONE;
        done_q <= 1'b1;
        complete_q <= (cnt_q == exp_cnt);
      end
    end
  end

  assign bus.idx_i     = i_q;
  assign bus.idx_j     = j_q;
  assign bus.idx_k     = k_q;
  assign bus.idx_p     = p_q;
  assign bus.idx_ri    = ri_q;
  assign bus.idx_rj    = rj_q;
  assign bus.dec_valid = vld_q;
  assign bus.combo_cnt = cnt_q;
  assign bus.done      = done_q;
  assign bus.complete  = complete_q;
  assign bus.pop_err   = pop_q;
  assign bus.order_err = order_q;
endmodule

// File: tb/tb_spare_signal_checker.sv
// Directed-vector bench for spare_signal_checker: full/partial sweeps, legality,
// ordering, reset and type-change handling.
module tb_spare_signal_checker;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  spare_signal_checker_if #(.CNT_W(9)) bus ();

  spare_signal_checker #(.EXP_S12(70), .EXP_S3(420), .CNT_W(9)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [7:0] d, input logic [3:0] r);
    bus.DSSS = d;
    bus.RLSS = r;
    @(posedge clk);
    #1;
  endtask

  task automatic set_type(input logic [1:0] t);
    bus.spare_struct_type = t;
    apply(8'h00, 4'h0);
  endtask

  task automatic chk_flags(input string tag, input int cnt, input int dn,
                           input int cp, input int pe, input int oe);
    chk({tag, ".cnt"},   int'(bus.combo_cnt), cnt);
    chk({tag, ".done"},  int'(bus.done), dn);
    chk({tag, ".cmpl"},  int'(bus.complete), cp);
    chk({tag, ".pop"},   int'(bus.pop_err), pe);
    chk({tag, ".order"}, int'(bus.order_err), oe);
  endtask

  task automatic chk_idx(input string tag, input int i, input int j, input int k, input int p);
    chk({tag, ".i"}, int'(bus.idx_i), i);
    chk({tag, ".j"}, int'(bus.idx_j), j);
    chk({tag, ".k"}, int'(bus.idx_k), k);
    chk({tag, ".p"}, int'(bus.idx_p), p);
  endtask

  // Descending generator-order S1 sweep, stopping after lim patterns.
  task automatic s1_sweep(input int lim);
    int n;
    n = 0;
    for (int v = 255; v >= 0 && n < lim; v--)
      if ($countones(v) == 4) begin
        apply(8'(v), 4'h0);
        n++;
        if (n == 1) begin
          chk("s1.first.vld", int'(bus.dec_valid), 1);
          chk_idx("s1.first", 7, 6, 5, 4);
          chk("s1.first.cnt", int'(bus.combo_cnt), 1);
        end
      end
  endtask

  // Descending S3 sweep: DSSS outer, RLSS inner, stopping after lim patterns.
  task automatic s3_sweep(input int lim);
    int n;
    n = 0;
    for (int d = 255; d >= 0 && n < lim; d--)
      if ($countones(d) == 4)
        for (int r = 15; r >= 0 && n < lim; r--)
          if ($countones(r) == 2) begin
            apply(8'(d), 4'(r));
            n++;
            if (n == 1) begin
              chk("s3.first.ri", int'(bus.idx_ri), 3);
              chk("s3.first.rj", int'(bus.idx_rj), 2);
              chk("s3.first.cnt", int'(bus.combo_cnt), 1);
            end else if (n == 2) begin
              chk("s3.second.ri", int'(bus.idx_ri), 3);
              chk("s3.second.rj", int'(bus.idx_rj), 1);
            end
          end
  endtask

  initial begin
    bus.spare_struct_type = 2'b01;
    bus.DSSS = 8'h00;
    bus.RLSS = 4'h0;
    rst = 1'b0;
    apply(8'h00, 4'h0);
    apply(8'h00, 4'h0);
    chk_flags("reset", 0, 0, 0, 0, 0);
    chk("reset.vld", int'(bus.dec_valid), 0);
    chk_idx("reset", 0, 0, 0, 0);
    rst = 1'b1;

    // Full S1 sweep
    s1_sweep(1000);
    chk_idx("s1.last", 3, 2, 1, 0);
    chk("s1.last.cnt", int'(bus.combo_cnt), 70);
    apply(8'h00, 4'h0);
    chk("s1.end.vld", int'(bus.dec_valid), 0);
    chk("s1.end.hold_i", int'(bus.idx_i), 3);
    chk_flags("s1.end", 70, 1, 1, 0, 0);

    // Pattern after DONE
    apply(8'hF0, 4'h0);
    chk_flags("s1.postdone", 70, 1, 1, 0, 1);

    // Type change to S3 with a pattern present: pattern ignored
    bus.spare_struct_type = 2'b11;
    apply(8'hF0, 4'hC);
    chk("chg.vld", int'(bus.dec_valid), 0);
    chk_flags("chg", 0, 0, 0, 0, 0);

    // Full S3 sweep
    s3_sweep(1000);
    chk("s3.last.cnt", int'(bus.combo_cnt), 420);
    apply(8'h00, 4'h0);
    chk_flags("s3.end", 420, 1, 1, 0, 0);

    // Reset mid-S3 sweep at 100
    rst = 1'b0;
    apply(8'h00, 4'h0);
    rst = 1'b1;
    s3_sweep(100);
    chk("s3mid.cnt", int'(bus.combo_cnt), 100);
    rst = 1'b0;
    apply(8'hF0, 4'hC);
    chk_flags("s3mid.rst", 0, 0, 0, 0, 0);
    chk("s3mid.rst.vld", int'(bus.dec_valid), 0);
    chk_idx("s3mid.rst", 0, 0, 0, 0);
    chk("s3mid.rst.ri", int'(bus.idx_ri), 0);
    rst = 1'b1;
    apply(8'h00, 4'h0);

    // Short S1 sweep of 10
    set_type(2'b01);
    s1_sweep(10);
    apply(8'h00, 4'h0);
    chk_flags("s1short", 10, 1, 0, 0, 0);

    // Order violation in S2
    set_type(2'b10);
    apply(8'hE8, 4'h0);
    apply(8'hF0, 4'h0);
    chk_flags("order", 2, 0, 0, 0, 1);

    // Popcount violations
    set_type(2'b01);
    set_type(2'b10);
    apply(8'h07, 4'h0);
    chk("pop.s2.err", int'(bus.pop_err), 1);
    chk_idx("pop.s2", 2, 1, 0, 0);
    chk("pop.s2.cnt", int'(bus.combo_cnt), 1);
    set_type(2'b11);
    chk("pop.clr", int'(bus.pop_err), 0);
    apply(8'hF0, 4'h8);
    chk("pop.s3.err", int'(bus.pop_err), 1);
    chk("pop.s3.ri", int'(bus.idx_ri), 3);
    chk("pop.s3.rj", int'(bus.idx_rj), 0);

    // Type change S1 -> S3 mid-run
    set_type(2'b01);
    apply(8'hF0, 4'h0);
    apply(8'hE8, 4'h0);
    apply(8'hE4, 4'h0);
    chk("midrun.cnt", int'(bus.combo_cnt), 3);
    set_type(2'b11);
    chk_flags("midrun.chg", 0, 0, 0, 0, 0);
    apply(8'hF0, 4'hC);
    chk_flags("midrun.restart", 1, 0, 0, 0, 0);

    // Disabled type ignores patterns
    set_type(2'b00);
    apply(8'hF0, 4'h0);
    chk("dis.vld", int'(bus.dec_valid), 0);
    chk("dis.cnt", int'(bus.combo_cnt), 0);
    apply(8'h00, 4'h0);
    chk("dis.done", int'(bus.done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/spare_signal_checker.md
Name: spare_signal_checker

Overview:
- Receive end of the spare-selection signal stream.
- Samples the DSSS (8-bit, 4-hot) and RLSS (4-bit, 2-hot) vectors produced by the spare signal generator each cycle.
- Decodes the set-bit positions back into spare indices, checks encoding legality and enumeration order, and counts combinations.
- Flags completion and whether the sweep was full-length. Sits between the generator and the spare-allocation evaluation logic.

Parameters:
- EXP_S12, 70, expected combination count for spare_struct_type S1/S2 (C(8,4)).
- EXP_S3, 420, expected combination count for S3 (C(8,4)·C(4,2)).
- CNT_W, 9, width of combo_cnt.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset
- spare_struct_type  input  2  01=S1, 10=S2, 11=S3, 00=disabled
- DSSS  input  8  dynamic spare selection vector from generator
- RLSS  input  4  row/local spare selection vector from generator
- idx_i  output  3  highest set DSSS bit position
- idx_j  output  3  2nd highest set DSSS bit
- idx_k  output  3  3rd highest set DSSS bit
- idx_p  output  3  lowest set DSSS bit
- idx_ri  output  2  higher set RLSS bit (0 in S1/S2)
- idx_rj  output  2  lower set RLSS bit (0 in S1/S2)
- dec_valid  output  1  idx_* valid this cycle
- combo_cnt  output  CNT_W  patterns accepted since sweep start
- done  output  1  sweep ended (sticky)
- complete  output  1  done with combo_cnt == expected (sticky)
- pop_err  output  1  illegal popcount seen (sticky)
- order_err  output  1  non-descending pattern seen (sticky)

Behaviour:
- Reset (rst==0 at clk edge): all outputs 0; state=IDLE; prev_key=0.
- Pattern present: DSSS != 0. Key = {DSSS,RLSS}, 12 bits. Expected count = EXP_S3 if type==S3, else EXP_S12.
- Type 00: block held in IDLE; no flags change except by reset.
- Latency: one cycle.
  - Pattern sampled at edge N gives idx_*, dec_valid=1 and the updated combo_cnt visible after edge N.
  - dec_valid=0 on cycles with no pattern; idx_* hold their last values.
- Decode:
  - idx_i > idx_j > idx_k > idx_p are the four set DSSS positions, high to low.
  - In S3, idx_ri > idx_rj are the two RLSS positions. In S1/S2, idx_ri = idx_rj = 0.
- Legality:
  - DSSS popcount must equal 4.
  - In S3, RLSS popcount must equal 2; in S1/S2, RLSS must be 0.
  - Violation: pop_err=1. The pattern is still counted. idx_* reflect the top set bits found, with missing positions set to 0.
- Order: each pattern's key must be strictly less than prev_key, because the generator sweeps in descending numeric order. Violation sets order_err=1. The first pattern of a sweep is exempt.
- FSM states:
  - IDLE: on a pattern (type != 00), go to RUN, set combo_cnt=1, prev_key=key.
  - RUN:
    - Pattern present: combo_cnt++ (saturates at all-ones), run the order check, prev_key=key.
    - No pattern: go to DONE; done=1; complete = (combo_cnt == expected).
  - DONE: holds. Any further pattern sets order_err=1 and is not counted. Exit only by reset or a type change.
- Type change: if spare_struct_type differs from its value last cycle, in any state:
  - go to IDLE;
  - clear combo_cnt, done, complete, pop_err, order_err and prev_key;
  - ignore the pattern present in that same cycle.
- Simultaneous events: reset has priority over type change; type change has priority over pattern processing.
- Reset mid-sweep: everything returns to reset values. A sweep that restarts afterwards is treated as a fresh sweep.

Test Plan:
- S1, generator-like stream 0xF0, 0xE8, …, 0x0F, then zero → first dec_valid gives idx=7,6,5,4; last gives 3,2,1,0; combo_cnt=70, done=1, complete=1, no errors.
- S3 full stream → first pattern DSSS=0xF0, RLSS=0xC gives ri=3, rj=2; second RLSS=0xA gives ri=3, rj=1; end state combo_cnt=420, complete=1.
- S1 stream stopped after 10 patterns, then zero → done=1, complete=0, combo_cnt=10.
- S2, DSSS=0x07 → pop_err=1, idx_i=2, idx_j=1, idx_k=0, idx_p=0. S3, DSSS=0xF0 with RLSS=0x8 → pop_err=1.
- S1, 0xE8 followed by 0xF0 → order_err=1. A pattern arriving while in DONE → order_err=1 and combo_cnt unchanged.
- rst=0 mid-S3 sweep at combo_cnt=100 → all outputs 0 next cycle. A type change S1→S3 mid-run → counters and flags cleared, back in IDLE.
